// File: rtl/pixel_link_defs.sv
// Shared definitions for the pixel-update serial link.
// Used by the game-side transmitter (pixel_spi_tx) and the display-side
// receiver, so the frame layout and FSM encoding stay identical on both ends.
//   FRAME_BITS       : bits per serial frame
//   *_MSB / *_LSB    : field positions of X, Y and DATA inside a frame
//   tx_state_e       : transmitter FSM state encoding
//   pack_frame()     : builds a frame word from its three fields
package pixel_link_defs;

    localparam int FRAME_BITS = 24;

    localparam int X_MSB    = 23;
    localparam int X_LSB    = 16;
    localparam int Y_MSB    = 15;
    localparam int Y_LSB    = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_e;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [7:0] x,
        input logic [7:0] y,
        input logic [7:0] data
    );
        logic [FRAME_BITS-1:0] f;
        f                   = '0;
        f[X_MSB:X_LSB]       = x;
        f[Y_MSB:Y_LSB]       = y;
        f[DATA_MSB:DATA_LSB] = data;
        return f;
    endfunction

endpackage

// File: rtl/pixel_tx_fifo.sv
// Small synchronous FIFO holding pending pixel writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wr_data this edge (ignored when full)
//   pop        : advance the read pointer this edge (ignored when empty)
//   wr_data    : word to store
//   rd_data    : oldest stored word, read straight from the storage flops
//   full/empty : occupancy flags, derived from the registered count only
//   level      : number of stored words (0..DEPTH)
module pixel_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // wraps modulo DEPTH
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Push and pop together leave the count unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/pixel_spi_tx.sv
// Pixel-update SPI transmitter (mode 0, 24-bit frames {X,Y,DATA}, MSB first).
//   CLOCK_50, RESET_N : system clock, asynchronous active-low reset
//   IN_VALID/IN_READY : pixel write handshake. A write transfers on a rising
//                       edge where IN_VALID && IN_READY; IN_READY depends only
//                       on registered FIFO occupancy, never on IN_VALID.
//   IN_X, IN_Y, IN_DATA : pixel fields, captured on the transfer edge
//   SPI_SCLK, SPI_MOSI, SPI_CS_N : serial link (SCLK idles low)
//   BUSY       : FSM is not in IDLE
//   FIFO_LEVEL : queued writes, not counting the frame in the shifter
module pixel_spi_tx
    import pixel_link_defs::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic [7:0]                    IN_X,
    input  logic [7:0]                    IN_Y,
    input  logic [7:0]                    IN_DATA,
    output logic                          SPI_SCLK,
    output logic                          SPI_MOSI,
    output logic                          SPI_CS_N,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    // One counter serves both the SCLK half-period divider and the gap timer.
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    // 24 bits -> 48 SCLK edges; index of the final (falling) edge.
    localparam logic [5:0]       LAST_TOG = 6'd47;

    tx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [5:0]              tog_q, tog_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_n_q, cs_n_d;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FRAME_BITS-1:0]   fifo_rd_data;

    assign fifo_push = IN_VALID && !fifo_full;
    assign IN_READY  = !fifo_full;

    pixel_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_BITS)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (pack_frame(IN_X, IN_Y, IN_DATA)),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (FIFO_LEVEL)
    );

    // MOSI is the shifter MSB: it moves only when the shifter moves, which
    // happens only on a falling SCLK edge, and clearing the shifter at the
    // end of a frame returns MOSI to 0.
    assign SPI_MOSI = shift_q[FRAME_BITS-1];
    assign SPI_SCLK = sclk_q;
    assign SPI_CS_N = cs_n_q;
    assign BUSY     = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tog_d    = tog_q;
        shift_d  = shift_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    cs_n_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_LEAD;
                end
            end

            ST_LEAD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    tog_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = '0;
                    sclk_d = !sclk_q;
                    tog_d  = tog_q + 6'd1;
                    if (sclk_q) begin
                        // Falling edge: the last one ends the frame and keeps
                        // bit 0 on MOSI through TRAIL.
                        if (tog_q == LAST_TOG) begin
                            state_d = ST_TRAIL;
                        end else begin
                            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_TRAIL: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    shift_d = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tog_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tog_q   <= tog_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
        end
    end

endmodule
